// File: rtl/reg_bus_responder.sv
// reg_bus_responder: responder end of the op/addr/wdata/rdata register bus.
// Holds ID, CTRL, STATUS, an event counter, W1C interrupt status with a mask,
// and NUM_SCRATCH scratch registers.
// Optional feature macro: REG_RSP_ERR_EN. When defined, IRQ_STAT.ERR (bit2)
// flags unmapped accesses, writes to read-only registers and illegal op 2'b11.
module reg_bus_responder #(
  parameter int unsigned DWIDTH      = 8,
  parameter int unsigned AWIDTH      = 8,
  parameter int unsigned NUM_SCRATCH = 4,
  parameter logic [7:0]  ID_VALUE    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        op,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata,
  input  logic              ev_in,
  output logic              ctrl_en,
  output logic              irq
);

  localparam int unsigned AW1      = AWIDTH + 1;
  localparam int unsigned SIW      = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;
  localparam int unsigned IRQ_BITS = 3;

  localparam logic [1:0] OP_RD = 2'b01;
  localparam logic [1:0] OP_WR = 2'b10;

  localparam logic [AWIDTH-1:0] A_ID    = AWIDTH'(8'h00);
  localparam logic [AWIDTH-1:0] A_CTRL  = AWIDTH'(8'h01);
  localparam logic [AWIDTH-1:0] A_STAT  = AWIDTH'(8'h02);
  localparam logic [AWIDTH-1:0] A_COUNT = AWIDTH'(8'h03);
  localparam logic [AWIDTH-1:0] A_ISTAT = AWIDTH'(8'h04);
  localparam logic [AWIDTH-1:0] A_IMASK = AWIDTH'(8'h05);
  localparam logic [AWIDTH-1:0] A_SCR   = AWIDTH'(8'h10);

`ifdef REG_RSP_ERR_EN
  localparam logic [IRQ_BITS-1:0] IRQ_WMASK = 3'b111;
`else
  localparam logic [IRQ_BITS-1:0] IRQ_WMASK = 3'b011;
`endif

  // Register state
  logic                en;
  logic [DWIDTH-1:0]   count;
  logic [IRQ_BITS-1:0] irq_stat;
  logic [IRQ_BITS-1:0] irq_mask;
  logic [DWIDTH-1:0]   scratch [NUM_SCRATCH];

  // Decode and next-value signals
  logic                is_rd, is_wr;
  logic                hit_id, hit_ctrl, hit_stat, hit_count, hit_istat, hit_imask;
  logic                hit_scr;
  logic [AWIDTH-1:0]   sidx;
  logic [SIW-1:0]      sidx_s;
  logic                wr_ctrl, wr_imask, wr_scr;
  logic                inc, clr, ovf_set;
  logic                err_set;
  logic [IRQ_BITS-1:0] w1c, stat_set;
  logic [DWIDTH-1:0]   rd_val;

  // Address decode, write strobes, counter/interrupt set terms and read mux
  always_comb begin
    is_rd     = (op == OP_RD);
    is_wr     = (op == OP_WR);
    hit_id    = (addr == A_ID);
    hit_ctrl  = (addr == A_CTRL);
    hit_stat  = (addr == A_STAT);
    hit_count = (addr == A_COUNT);
    hit_istat = (addr == A_ISTAT);
    hit_imask = (addr == A_IMASK);
    sidx      = addr - A_SCR;
    sidx_s    = sidx[SIW-1:0];
    hit_scr   = (addr >= A_SCR) && ({1'b0, sidx} < AW1'(NUM_SCRATCH));

    wr_ctrl   = is_wr && hit_ctrl;
    wr_imask  = is_wr && hit_imask;
    wr_scr    = is_wr && hit_scr;
    w1c       = (is_wr && hit_istat) ? (wdata[IRQ_BITS-1:0] & IRQ_WMASK) : '0;

    // CLR wins over a same-edge increment, so a wrap is suppressed with it
    clr       = wr_ctrl && wdata[1];
    inc       = ev_in && en;
    ovf_set   = inc && !clr && (&count);

`ifdef REG_RSP_ERR_EN
    err_set   = (op == 2'b11) ||
                ((is_rd || is_wr) &&
                 !(hit_id || hit_ctrl || hit_stat || hit_count ||
                   hit_istat || hit_imask || hit_scr)) ||
                (is_wr && (hit_id || hit_stat || hit_count));
`else
    err_set   = 1'b0;
`endif
    stat_set  = {err_set, inc, ovf_set};

    rd_val = '0;
    if (hit_id)         rd_val = DWIDTH'(ID_VALUE);
    else if (hit_ctrl)  rd_val = DWIDTH'(en);
    else if (hit_stat)  rd_val = DWIDTH'({(count == '0), en});
    else if (hit_count) rd_val = count;
    else if (hit_istat) rd_val = DWIDTH'(irq_stat);
    else if (hit_imask) rd_val = DWIDTH'(irq_mask);
    else if (hit_scr)   rd_val = scratch[sidx_s];
  end

  // Register bank update; reset overrides any op on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata    <= '0;
      en       <= 1'b0;
      count    <= '0;
      irq_stat <= '0;
      irq_mask <= '0;
      for (int i = 0; i < int'(NUM_SCRATCH); i++) scratch[i] <= '0;
    end else begin
      if (is_rd)   rdata <= rd_val;
      if (wr_ctrl) en <= wdata[0];
      if (clr)      count <= '0;
      else if (inc) count <= count + DWIDTH'(1);
      // Hardware set terms are OR-ed after the clear so a set wins
      irq_stat <= (irq_stat & ~w1c) | stat_set;
      if (wr_imask) irq_mask <= wdata[IRQ_BITS-1:0] & IRQ_WMASK;
      if (wr_scr)   scratch[sidx_s] <= wdata;
    end
  end

  // Control mirror and level interrupt from flopped status and mask
  assign ctrl_en = en;
  assign irq     = |(irq_stat & irq_mask);

endmodule

// File: tb/tb_reg_bus_responder.sv
// tb_reg_bus_responder: directed bench; read expectations go into a queue
// and a monitor compares them against rdata one cycle after each RD.
module tb_reg_bus_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] op;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ev_in;
  logic       ctrl_en;
  logic       irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q [$];

`ifdef REG_RSP_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  reg_bus_responder #(
    .DWIDTH(8), .AWIDTH(8), .NUM_SCRATCH(4), .ID_VALUE(8'hA5)
  ) dut (
    .clk(clk), .rst(rst), .op(op), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ev_in(ev_in), .ctrl_en(ctrl_en), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, got, exp);
    end
  endtask

  // One bus cycle: drive, let the edge sample it, return 1ns later with NOP
  task automatic bus(input logic [1:0] o, input logic [7:0] a, input logic [7:0] d);
    op = o; addr = a; wdata = d;
    @(posedge clk); #1;
    op = 2'b00;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus(2'b10, a, d);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp);
    exp_q.push_back(exp);
    bus(2'b01, a, 8'h00);
  endtask

  // Monitor: an RD sampled at a posedge is compared on the following negedge
  initial begin
    logic was_rd;
    logic [7:0] e;
    forever begin
      @(posedge clk);
      was_rd = (op == 2'b01) && !rst;
      @(negedge clk);
      if (was_rd) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rdata_unexpected: got 0x%02h, expected no read", rdata);
        end else begin
          e = exp_q.pop_front();
          if (rdata !== e) begin
            n_fail++;
            $display("FAIL rdata: got 0x%02h, expected 0x%02h", rdata, e);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; op = 2'b00; addr = 8'h00; wdata = 8'h00; ev_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", rdata, 8'h00);
    check("reset_ctrl_en", {7'd0, ctrl_en}, 8'h00);
    check("reset_irq", {7'd0, irq}, 8'h00);
    rst = 1'b0;

    // ID and reset register values
    rd(8'h00, 8'hA5);
    rd(8'h01, 8'h00);
    rd(8'h02, 8'h02);
    rd(8'h03, 8'h00);
    rd(8'h04, 8'h00);

    // Scratch read-after-write and range edges
    wr(8'h10, 8'h5A);
    rd(8'h10, 8'h5A);
    wr(8'h13, 8'hFF);
    rd(8'h13, 8'hFF);
    rd(8'h14, 8'h00);
    wr(8'h14, 8'h77);
    rd(8'h14, 8'h00);
    rd(8'h10, 8'h5A);
    wr(8'h04, 8'h04);
    rd(8'h04, 8'h00);

    // Counter wrap after 256 events
    wr(8'h01, 8'h01);
    check("ctrl_en_set", {7'd0, ctrl_en}, 8'h01);
    ev_in = 1'b1;
    repeat (256) @(posedge clk);
    #1 ev_in = 1'b0;
    rd(8'h03, 8'h00);
    rd(8'h04, 8'h03);
    rd(8'h02, 8'h03);
    wr(8'h05, 8'h01);
    check("irq_ovf_masked", {7'd0, irq}, 8'h01);
    wr(8'h04, 8'h01);
    check("irq_after_w1c", {7'd0, irq}, 8'h00);
    rd(8'h04, 8'h02);

    // CLR beats a same-edge increment
    ev_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rd(8'h03, 8'h03);
    wr(8'h01, 8'h03);
    rd(8'h03, 8'h00);
    ev_in = 1'b0;
    rd(8'h03, 8'h01);
    rd(8'h01, 8'h01);
    rd(8'h04, 8'h02);

    // W1C collides with an EVT set: set wins
    ev_in = 1'b1;
    wr(8'h04, 8'h02);
    ev_in = 1'b0;
    rd(8'h04, 8'h02);
    wr(8'h04, 8'h02);
    rd(8'h04, 8'h00);
    rd(8'h03, 8'h02);
    wr(8'h05, 8'hFF);
    rd(8'h05, ERR_ON ? 8'h07 : 8'h03);

    // Error reporting for unmapped, read-only and illegal accesses
    wr(8'h05, 8'h04);
    wr(8'h07, 8'h11);
    rd(8'h04, ERR_ON ? 8'h04 : 8'h00);
    check("irq_err", {7'd0, irq}, ERR_ON ? 8'h01 : 8'h00);
    wr(8'h04, 8'h04);
    check("irq_err_cleared", {7'd0, irq}, 8'h00);
    wr(8'h03, 8'h55);
    rd(8'h03, 8'h02);
    rd(8'h04, ERR_ON ? 8'h04 : 8'h00);
    wr(8'h04, 8'h04);
    bus(2'b11, 8'h10, 8'h33);
    rd(8'h04, ERR_ON ? 8'h04 : 8'h00);
    rd(8'h10, 8'h5A);

    // Reset beats a same-edge read and write
    rd(8'h13, 8'hFF);
    rst = 1'b1;
    bus(2'b01, 8'h00, 8'h00);
    check("rst_rd_rdata", rdata, 8'h00);
    bus(2'b10, 8'h10, 8'h99);
    rst = 1'b0;
    check("rst_ctrl_en", {7'd0, ctrl_en}, 8'h00);
    check("rst_irq", {7'd0, irq}, 8'h00);
    rd(8'h10, 8'h00);
    rd(8'h03, 8'h00);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending reads, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
